// File: rtl/online_pkg.sv
// Shared definitions for radix-2 on-line operators: borrow-save digit encodings
// and a decoder from (plus, minus) to the signed digit value.
`default_nettype none

package online_pkg;

  localparam logic [1:0] DIG_POS   = 2'b10;
  localparam logic [1:0] DIG_NEG   = 2'b01;
  localparam logic [1:0] DIG_ZERO0 = 2'b00;
  localparam logic [1:0] DIG_ZERO1 = 2'b11;

  function automatic logic signed [1:0] sd_value(input logic plus, input logic minus);
    logic signed [1:0] v;
    case ({plus, minus})
      DIG_POS: v = 2'sd1;
      DIG_NEG: v = -2'sd1;
      default: v = 2'sd0;
    endcase
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/online_to_binary_if.sv
// Digit-stream input and parallel-result output of the on-line to binary converter.
`default_nettype none

interface online_to_binary_if #(
  parameter int N = 8
);
  localparam int W = N + 1;

  logic         d_plus;
  logic         d_minus;
  logic         in_valid;
  logic         in_first;
  logic         in_ready;
  logic [W-1:0] result;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output d_plus, d_minus, in_valid, in_first, out_ready,
    input  in_ready, result, out_valid
  );

  modport slave (
    input  d_plus, d_minus, in_valid, in_first, out_ready,
    output in_ready, result, out_valid
  );

endinterface

`default_nettype wire

// File: rtl/online_to_binary_otf_step.sv
// One on-the-fly conversion step: appends a signed digit to the Q/QM pair.
`default_nettype none

module otf_step
  import online_pkg::*;
#(
  parameter int W = 9
) (
  input  logic [W-1:0] q_i,
  input  logic [W-1:0] qm_i,
  input  logic         plus_i,
  input  logic         minus_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] qm_o
);

  logic [W-1:0] q_sh;
  logic [W-1:0] qm_sh;

  assign q_sh  = q_i << 1;
  assign qm_sh = qm_i << 1;

  // Q and QM both shift left; the digit selects which one feeds each and the new LSB.
  always_comb begin
    q_o  = q_sh;
    qm_o = qm_sh | W'(1);
    case (sd_value(plus_i, minus_i))
      2'sd1: begin
        q_o  = q_sh | W'(1);
        qm_o = q_sh;
      end
      -2'sd1: begin
        q_o  = qm_sh | W'(1);
        qm_o = qm_sh;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/online_to_binary.sv
// Converts an MSB-first borrow-save digit frame of N digits into an (N+1)-bit
// two's-complement word, delivered through a valid/ready output register.
`default_nettype none

module online_to_binary #(
  parameter int N = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  online_to_binary_if.slave  bus
);

  localparam int              W     = N + 1;
  localparam int              CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(N - 1);

  logic [W-1:0]     q_q, qm_q;
  logic [W-1:0]     q_d, qm_d;
  logic [W-1:0]     base_q, base_qm;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q;
  logic [W-1:0]     result_q;
  logic             out_valid_q;
  logic             take;
  logic             done;

  assign bus.in_ready = !(active_q && (cnt_q == CNT_PEN) && !bus.in_first
                          && out_valid_q && !bus.out_ready);

  assign base_q  = bus.in_first ? '0 : q_q;
  assign base_qm = bus.in_first ? '1 : qm_q;

  otf_step #(.W(W)) u_step (
    .q_i     (base_q),
    .qm_i    (base_qm),
    .plus_i  (bus.d_plus),
    .minus_i (bus.d_minus),
    .q_o     (q_d),
    .qm_o    (qm_d)
  );

  // Orphan digits (no in_first while idle) are accepted but have no effect.
  assign take  = bus.in_valid && bus.in_ready && (bus.in_first || active_q);
  assign cnt_d = bus.in_first ? CNT_W'(1) : cnt_q + CNT_W'(1);
  assign done  = take && (cnt_d == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q         <= '0;
      qm_q        <= '1;
      cnt_q       <= '0;
      active_q    <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (done) begin
        result_q <= q_d;
        q_q      <= '0;
        qm_q     <= '1;
        cnt_q    <= '0;
        active_q <= 1'b0;
      end else if (take) begin
        q_q      <= q_d;
        qm_q     <= qm_d;
        cnt_q    <= cnt_d;
        active_q <= 1'b1;
      end

      if (done) begin
        out_valid_q <= 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.result    = result_q;
  assign bus.out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_online_to_binary.sv
// Randomised scoreboard bench for online_to_binary with an arithmetic frame model.
`default_nettype none

module tb_online_to_binary;

  localparam int N = 8;
  localparam int W = N + 1;

  logic clk;
  logic rst_n;

  online_to_binary_if #(.N(N)) bus ();

  online_to_binary #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic [W-1:0] sb[$];

  // Reference model: frame value accumulated as an integer sum of d_i * 2^(N-i).
  bit m_active;
  int m_cnt;
  int m_acc;
  bit m_valid;

  task automatic model_reset();
    m_active = 1'b0;
    m_cnt    = 0;
    m_acc    = 0;
    m_valid  = 1'b0;
    sb.delete();
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented result must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mon_en && rst_n && bus.out_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected: got %0h with no expected result", bus.result);
      end else begin
        if (bus.result !== sb[0]) begin
          errors++;
          $display("FAIL result: got %0h expected %0h at %0t", bus.result, sb[0], $time);
        end
        if (bus.out_ready) void'(sb.pop_front());
      end
    end
  end

  // One cycle of stimulus: drive after posedge, check and advance the model at negedge.
  task automatic step(input bit v, input bit f, input int d, input bit ordy, input bit zalt);
    bit exp_ready, acc, done;
    @(posedge clk);
    #1;
    bus.in_valid  = v;
    bus.in_first  = f;
    bus.out_ready = ordy;
    case (d)
      1:       {bus.d_plus, bus.d_minus} = 2'b10;
      -1:      {bus.d_plus, bus.d_minus} = 2'b01;
      default: {bus.d_plus, bus.d_minus} = zalt ? 2'b11 : 2'b00;
    endcase
    @(negedge clk);
    exp_ready = !(m_active && m_cnt == N - 1 && !f && m_valid && !ordy);
    check("in_ready", bus.in_ready, exp_ready);
    check("out_valid", bus.out_valid, m_valid);
    acc  = v && exp_ready && (f || m_active);
    done = 1'b0;
    if (acc) begin
      if (f) begin
        m_cnt = 1;
        m_acc = d;
      end else begin
        m_cnt = m_cnt + 1;
        m_acc = m_acc * 2 + d;
      end
      if (m_cnt == N) begin
        sb.push_back(W'(m_acc));
        done     = 1'b1;
        m_active = 1'b0;
        m_cnt    = 0;
      end else begin
        m_active = 1'b1;
      end
    end
    if (done) m_valid = 1'b1;
    else if (m_valid && ordy) m_valid = 1'b0;
  endtask

  task automatic frame(input int digs[N], input int zpos);
    for (int i = 0; i < N; i++) step(1'b1, i == 0, digs[i], 1'b1, i == zpos);
  endtask

  task automatic expect_result(input string name, input logic [W-1:0] val);
    step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    check(name, bus.result, val);
  endtask

  int f_allpos[N]  = '{1, 1, 1, 1, 1, 1, 1, 1};
  int f_negpos[N]  = '{-1, 0, 0, 0, 0, 0, 0, 1};
  int f_red_a[N]   = '{1, -1, 0, 0, 0, 0, 0, 0};
  int f_red_b[N]   = '{0, 1, 0, 0, 0, 0, 0, 0};

  initial begin
    bus.in_valid = 0; bus.in_first = 0; bus.d_plus = 0; bus.d_minus = 0; bus.out_ready = 0;
    rst_n = 1'b0;
    model_reset();
    #12;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_result", bus.result, 0);
    check("reset_in_ready", bus.in_ready, 1);
    rst_n = 1'b1;
    mon_en = 1'b1;

    frame(f_allpos, -1);
    expect_result("all_pos", 9'h0FF);
    frame(f_negpos, -1);
    expect_result("neg_pos", 9'h181);
    frame(f_negpos, 3);
    expect_result("neg_pos_z11", 9'h181);
    frame(f_red_a, -1);
    expect_result("redundant_a", 9'h040);
    frame(f_red_b, -1);
    expect_result("redundant_b", 9'h040);

    // Backpressure: first result waits while the second frame streams up to its last digit.
    frame(f_allpos, -1);
    for (int i = 0; i < N; i++) step(1'b1, i == 0, f_negpos[i], 1'b0, 1'b0);
    check("bp_in_ready_low", bus.in_ready, 0);
    check("bp_hold", bus.result, 9'h0FF);
    step(1'b1, 1'b0, 1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1, 1'b1, 1'b0);
    expect_result("bp_second", 9'h181);

    // Abort after 4 digits, then orphans while idle.
    for (int i = 0; i < 4; i++) step(1'b1, i == 0, 1, 1'b1, 1'b0);
    frame(f_negpos, 5);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1, 1'b1, 1'b0);
    check("orphan_no_valid", bus.out_valid, 0);

    // Async reset mid-frame while a result is pending.
    frame(f_allpos, -1);
    for (int i = 0; i < 4; i++) step(1'b1, i == 0, -1, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", bus.out_valid, 0);
    check("async_result", bus.result, 0);
    model_reset();
    rst_n = 1'b1;
    frame(f_red_a, 2);
    expect_result("after_reset", 9'h040);

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      bit v, f, ordy;
      int d;
      v    = ($urandom_range(0, 9) < 7);
      f    = m_active ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 7) != 0);
      ordy = ($urandom_range(0, 9) < 6);
      d    = int'($urandom_range(0, 2)) - 1;
      step(v, f, d, ordy, $urandom_range(0, 1) == 1);
    end

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    check("drain_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/online_to_binary.md
Name: online_to_binary

Overview:
- Receiver end of the radix-2 on-line adder datapath.
- Consumes an MSB-first serial stream of signed digits in borrow-save (plus/minus) form, such as the adder's z output.
- Uses on-the-fly conversion to produce a conventional two's-complement word with no final carry-propagate addition.
- Sits after the on-line adder or other on-line operators; hands parallel results to conventional logic through a valid/ready handshake.

Parameters:
- N, 8: digits per frame; legal range N >= 2.
- W, N+1: result width (derived, not overridable). One integer/sign bit plus N fraction bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- d_plus  input  1  plus bit of the current digit.
- d_minus  input  1  minus bit of the current digit. Digit value d = d_plus - d_minus; 11 is a legal encoding of 0.
- in_valid  input  1  the digit is presented this cycle.
- in_first  input  1  qualifies in_valid: this digit is the MSB (weight 2^-1) of a new frame.
- in_ready  output  1  the digit is accepted when in_valid && in_ready.
- result  output  W  two's-complement value of sum(d_i * 2^-i), i = 1..N, scaled by 2^N.
- out_valid  output  1  result holds a completed frame.
- out_ready  input  1  downstream accepts result.

Behaviour:
- Reset (async, rst_n=0):
  - Q = 0 and QM = all ones (-1).
  - cnt = 0, active = 0, result = 0, out_valid = 0.
  - in_ready = 1 immediately.
  - Applies mid-frame: the partial frame is discarded and any pending result is lost.
- Internal state:
  - Q and QM, each W bits; QM = Q - 1 ulp invariant.
  - cnt, digits accepted, clog2(N+1) bits.
  - active flag.
- On-the-fly update when a digit is accepted. The base is the live Q/QM, or Q=0 / QM=-1 if in_first.
  - d=+1: Q <= {Q[W-2:0],1}; QM <= {Q[W-2:0],0}.
  - d= 0: Q <= {Q[W-2:0],0}; QM <= {QM[W-2:0],1}.
  - d=-1: Q <= {QM[W-2:0],1}; QM <= {QM[W-2:0],0}.
- Frame control:
  - in_valid && in_first: starts a new frame (cnt <= 1, active = 1). Any frame in progress is abandoned silently, with no result.
  - in_valid && !in_first && active: continues the frame (cnt <= cnt+1).
  - in_valid && !in_first && !active: digit ignored, state unchanged. in_ready is still high.
  - Gaps (in_valid=0) are allowed anywhere; state holds.
- Completion:
  - When the accepted digit makes cnt reach N, the next-state Q is loaded into result and out_valid is set at the next edge.
  - In the same cycle: active <= 0, cnt <= 0, Q/QM reinitialised.
  - Latency is 1 clock from the final digit to out_valid.
- Output handshake:
  - result and out_valid are held stable until out_valid && out_ready.
  - Then out_valid drops on the next edge, unless a new completion loads on that same edge; in that case out_valid stays 1 with the new result.
- Backpressure:
  - in_ready = 0 only when the next accepted digit would complete a frame (active && cnt==N-1, without in_first) while out_valid && !out_ready.
  - Otherwise in_ready = 1. Non-final digits always flow.
  - in_first is always accepted. Reason: a frame starting with in_first never completes on that cycle when N >= 2.
- Range: value in (-1, 1) maps exactly into W bits; the conversion cannot overflow.

Decomposition:
- Shared package online_pkg:
  - digit encoding constants DIG_POS=2'b10, DIG_NEG=2'b01, DIG_ZERO0=2'b00, DIG_ZERO1=2'b11.
  - function sd_value(plus, minus) returning -1/0/+1.
  - Reused by the adder benches and future on-line operators.
- One natural sub-module: otf_step, a combinational next-Q/next-QM for one digit given W. The top holds cnt, active, the output register and the handshake.

Test Plan:
- N=8, frame of all +1, out_ready=1:
  - Response: out_valid one cycle after digit 8; result = 9'h0FF (255/256).
- N=8, digits -1,0,0,0,0,0,0,+1:
  - Response: result = -128 + 1 = 9'h181.
  - Also exercise the 11 encoding of zero in a middle position; the result must be identical.
- Redundancy check: +1,-1,0,... (value 1/4) vs 0,+1,0,...
  - Response: both yield result = 9'h040.
- Backpressure:
  - Complete a frame, hold out_ready=0, stream the next frame.
  - Response: in_ready drops only on its 8th digit; the first result stays stable.
  - Raising out_ready: the first result is consumed, the 8th digit is accepted, and the second result appears the next cycle.
- Abort and orphan handling:
  - in_first mid-frame after 4 digits: old frame dropped, no out_valid; the new frame converts correctly.
  - Digits without in_first while idle: ignored.
- Async reset:
  - rst_n low for a partial cycle at digit 5 with out_valid=1.
  - Response: out_valid=0 and result=0 immediately; the next framed input converts correctly.
